// File: rtl/wb_burst_master.sv
// Wishbone classic self-test master: writes seed+i to base+4*i for L beats,
// idles one cycle, reads the same words back and counts mismatches.
module wb_burst_master #(
  parameter int  AW     = 26,
  parameter int  DW     = 32,
  parameter int  BL_MAX = 8,
  parameter int  TO_CYC = 256,
  localparam int LW     = $clog2(BL_MAX + 1),
  localparam int TW     = $clog2(TO_CYC)
) (
  input  logic            wb_clk_i,
  input  logic            resetn,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [LW-1:0]   burst_len,
  input  logic [DW-1:0]   seed,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [LW-1:0]   err_cnt,
  output logic            timeout
);

  typedef enum logic [2:0] {IDLE, WR, GAP, RD, FIN} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   last_q, last_d;
  logic [TW-1:0]   to_q, to_d;
  logic [AW-1:0]   base_q, base_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [LW-1:0]   err_d;
  logic            tmo_d, pass_d, ack_ok, cyc_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   dat_d;

  // Index of the final beat: 0 means one beat, oversize requests clip to BL_MAX.
  function automatic logic [LW-1:0] last_beat(input logic [LW-1:0] n);
    if (n == '0) return '0;
    if (n > LW'(BL_MAX)) return LW'(BL_MAX - 1);
    return n - LW'(1);
  endfunction

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == '1) ? v : v + LW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    to_d    = to_q;
    base_d  = base_q;
    seed_d  = seed_q;
    err_d   = err_cnt;
    tmo_d   = timeout;
    pass_d  = pass;
    ack_ok  = wb_ack_i && wb_stb_o;
    case (state_q)
      IDLE: if (start) begin
        state_d = WR;
        beat_d  = '0;
        to_d    = '0;
        base_d  = base_addr;
        seed_d  = seed;
        last_d  = last_beat(burst_len);
        err_d   = '0;
        tmo_d   = 1'b0;
        pass_d  = 1'b0;
      end
      WR, RD: begin
        if (ack_ok) begin
          to_d = '0;
          if (state_q == RD && wb_dat_i != seed_q + DW'(beat_q))
            err_d = sat_inc(err_cnt);
          if (beat_q == last_q) begin
            state_d = (state_q == WR) ? GAP : FIN;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end else if (to_q == TW'(TO_CYC - 1)) begin
          state_d = FIN;
          tmo_d   = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      GAP: begin
        state_d = RD;
        beat_d  = '0;
        to_d    = '0;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Result is fixed on entry to FIN so it is valid alongside done.
    if (state_d == FIN && state_q != FIN)
      pass_d = (err_d == '0) && !tmo_d;
    cyc_d  = (state_d == WR) || (state_d == RD);
    addr_d = cyc_d ? base_d + (AW'(beat_d) << 2) : '0;
    dat_d  = (state_d == WR) ? seed_d + DW'(beat_d) : '0;
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      to_q      <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      to_q      <= to_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= cyc_d;
      wb_we_o   <= (state_d == WR);
      wb_sel_o  <= cyc_d ? '1 : '0;
      wb_addr_o <= addr_d;
      wb_dat_o  <= dat_d;
      busy      <= (state_d == WR) || (state_d == GAP) || (state_d == RD);
      done      <= (state_d == FIN);
      pass      <= pass_d;
      err_cnt   <= err_d;
      timeout   <= tmo_d;
    end
  end

  // Burst parameters are plain data; they are only consumed after a start.
  always_ff @(posedge wb_clk_i) begin
    base_q <= base_d;
    seed_q <= seed_d;
    last_q <= last_d;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a configurable Wishbone slave model
// (wait states, read corruption by beat index, never-ack).
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [25:0] base_addr = '0;
  logic [3:0]  burst_len = '0;
  logic [31:0] seed = '0;
  logic        cyc, stb, we, ack, busy, done, pass, timeout;
  logic [3:0]  sel, err_cnt;
  logic [25:0] addr;
  logic [31:0] dat_o, dat_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_burst_master dut (
    .wb_clk_i (clk),       .resetn   (resetn),  .start    (start),
    .base_addr(base_addr), .burst_len(burst_len), .seed   (seed),
    .wb_cyc_o (cyc),       .wb_stb_o (stb),     .wb_we_o  (we),
    .wb_sel_o (sel),       .wb_addr_o(addr),    .wb_dat_o (dat_o),
    .wb_ack_i (ack),       .wb_dat_i (dat_i),   .busy     (busy),
    .done     (done),      .pass     (pass),    .err_cnt  (err_cnt),
    .timeout  (timeout)
  );

  // Slave model
  logic [3:0]  ws = 4'd0;
  logic        noack = 1'b0;
  logic [7:0]  corrupt = 8'h00;
  logic [3:0]  wait_cnt = 4'd0;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] mem [0:63];
  logic [25:0] wlog_a [0:127];
  logic [31:0] wlog_d [0:127];
  int          wcnt = 0;

  assign ack   = stb && !noack && (wait_cnt == ws);
  assign dat_i = mem[addr[7:2]] ^ {31'b0, corrupt[rd_idx]};

  always @(posedge clk) begin
    if (!stb || ack) wait_cnt <= 4'd0;
    else             wait_cnt <= wait_cnt + 4'd1;
    if (!cyc)              rd_idx <= 3'd0;
    else if (ack && !we)   rd_idx <= rd_idx + 3'd1;
    if (ack && we) begin
      mem[addr[7:2]]      <= dat_o;
      wlog_a[wcnt & 127]  <= addr;
      wlog_d[wcnt & 127]  <= dat_o;
      wcnt                <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic kick(input logic [25:0] b, input logic [3:0] l, input logic [31:0] s);
    base_addr = b; burst_len = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (!done && n < budget) begin @(posedge clk); #1; n++; end
    chk("done_seen", {63'b0, done}, 64'd1);
  endtask

  int n, w0;

  initial begin
    // Reset state
    #12;
    chk("rst_cyc",  {63'b0, cyc}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_sel",  {60'b0, sel}, 64'd0);
    @(negedge clk); resetn = 1'b1;
    step(2);

    // Zero-wait, base 0x100, L=4
    w0 = wcnt;
    kick(26'h100, 4'd4, 32'hA5A5_0000);
    chk("t1_cyc",  {61'b0, cyc, stb, we}, 64'h7);
    chk("t1_sel",  {60'b0, sel}, 64'hF);
    chk("t1_addr", {38'b0, addr}, 64'h100);
    chk("t1_dat",  {32'b0, dat_o}, 64'hA5A5_0000);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    wait_done(1, 40, n);
    chk("t1_lat",  64'(n), 64'd10);
    chk("t1_res",  {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b1, 1'b0, 4'd0});
    chk("t1_idle", {61'b0, cyc, stb, busy}, 64'd0);
    chk("t1_nwr",  64'(wcnt - w0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wa", {38'b0, wlog_a[(w0 + i) & 127]}, 64'h100 + 64'(4 * i));
      chk("t1_wd", {32'b0, wlog_d[(w0 + i) & 127]}, 64'hA5A5_0000 + 64'(i));
    end
    step(1);
    chk("t1_pulse", {63'b0, done}, 64'd0);
    chk("t1_hold",  {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b1, 1'b0, 4'd0});

    // Three wait states per beat, L=8
    ws = 4'd3;
    w0 = wcnt;
    kick(26'h40, 4'd8, 32'h0000_1000);
    step(2);
    chk("t2_stb3",  {63'b0, stb}, 64'd1);
    chk("t2_addr3", {38'b0, addr}, 64'h40);
    chk("t2_dat3",  {32'b0, dat_o}, 64'h1000);
    step(1);
    chk("t2_addr4", {38'b0, addr}, 64'h40);
    step(1);
    chk("t2_addr5", {38'b0, addr}, 64'h44);
    chk("t2_dat5",  {32'b0, dat_o}, 64'h1001);
    wait_done(5, 120, n);
    chk("t2_lat",  64'(n), 64'd66);
    chk("t2_res",  {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b1, 1'b0, 4'd0});
    chk("t2_last", {38'b0, wlog_a[(w0 + 7) & 127]}, 64'h5C);
    ws = 4'd0;
    step(1);

    // Read beats 1 and 5 corrupted, L=8
    corrupt = 8'b0010_0010;
    kick(26'h180, 4'd8, 32'h7777_0000);
    wait_done(1, 40, n);
    chk("t3_lat", 64'(n), 64'd18);
    chk("t3_res", {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b0, 1'b0, 4'd2});
    corrupt = 8'h00;
    step(1);

    // Slave never acks
    noack = 1'b1;
    kick(26'h200, 4'd2, 32'h0);
    step(255);
    chk("t4_cyc256", {62'b0, cyc, stb}, 64'h3);
    chk("t4_done256", {63'b0, done}, 64'd0);
    step(1);
    chk("t4_drop", {62'b0, cyc, stb}, 64'd0);
    chk("t4_done", {63'b0, done}, 64'd1);
    chk("t4_res",  {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b0, 1'b1, 4'd0});
    noack = 1'b0;
    step(1);

    // Address wrap at the top of the space
    w0 = wcnt;
    kick(26'h3FF_FFF8, 4'd4, 32'h1234_5678);
    wait_done(1, 40, n);
    chk("t5_pass", {63'b0, pass}, 64'd1);
    chk("t5_a0",   {38'b0, wlog_a[w0 & 127]}, 64'h3FF_FFF8);
    chk("t5_a2",   {38'b0, wlog_a[(w0 + 2) & 127]}, 64'h0);
    chk("t5_a3",   {38'b0, wlog_a[(w0 + 3) & 127]}, 64'h4);
    chk("t5_d3",   {32'b0, wlog_d[(w0 + 3) & 127]}, 64'h1234_567B);
    step(1);

    // burst_len 0 acts as one beat
    w0 = wcnt;
    kick(26'h300, 4'd0, 32'h5555_0000);
    wait_done(1, 40, n);
    chk("t6_lat",  64'(n), 64'd4);
    chk("t6_nwr",  64'(wcnt - w0), 64'd1);
    chk("t6_pass", {63'b0, pass}, 64'd1);
    step(1);

    // burst_len 15 clips to 8
    w0 = wcnt;
    kick(26'h80, 4'd15, 32'h9000_0000);
    wait_done(1, 40, n);
    chk("t7_lat",  64'(n), 64'd18);
    chk("t7_nwr",  64'(wcnt - w0), 64'd8);
    chk("t7_last", {38'b0, wlog_a[(w0 + 7) & 127]}, 64'h9C);
    step(1);

    // Asynchronous reset in the middle of the read burst
    kick(26'h100, 4'd8, 32'hDEAD_0000);
    step(11);
    chk("t8_inrd", {61'b0, cyc, we, busy}, 64'h5);
    #3 resetn = 1'b0;
    #1;
    chk("t8_ctl",  {59'b0, cyc, stb, we, busy, done}, 64'd0);
    chk("t8_bus",  {2'b0, sel, addr, dat_o}, 64'd0);
    base_addr = 26'h300; burst_len = 4'd4; seed = 32'h0F0F_0000; start = 1'b1;
    step(2);
    chk("t8_held", {62'b0, cyc, busy}, 64'd0);
    #2 resetn = 1'b1;
    kick(26'h300, 4'd4, 32'h0F0F_0000);
    chk("t8_go",   {63'b0, cyc}, 64'd1);
    wait_done(1, 40, n);
    chk("t8_lat",  64'(n), 64'd10);
    chk("t8_res",  {58'b0, pass, timeout, err_cnt}, {58'b0, 1'b1, 1'b0, 4'd0});

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
